// File: rtl/vidscan.sv
// 320x200 8-bit page scanout to 640x480@60 VGA with 2x2 doubling, 40-line borders and a ping-pong line buffer.
// Build option: VIDSCAN_PAGE_LATCH_EN latches `page` once per frame for tear-free flips.
module vidscan (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        page,
  output logic        req,
  input  logic        gnt,
  output logic [17:0] a,
  input  logic [7:0]  i,
  output logic [7:0]  px,
  output logic        de,
  output logic        hs,
  output logic        vs,
  output logic        urun
);
  localparam int unsigned H_LAST    = 799;
  localparam int unsigned V_LAST    = 524;
  localparam int unsigned H_VIS     = 640;
  localparam int unsigned V_VIS     = 480;
  localparam int unsigned HS_BEG    = 656;
  localparam int unsigned HS_END    = 751;
  localparam int unsigned VS_BEG    = 490;
  localparam int unsigned VS_END    = 491;
  localparam int unsigned IMG_TOP   = 40;
  localparam int unsigned IMG_BOT   = 440;
  localparam int unsigned LAST_TRIG = 437;
  localparam int unsigned LINE_W    = 320;
  localparam int unsigned CW        = 9;
  localparam int unsigned AW        = 17;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} fetch_state_t;

  logic [9:0]    hc, vc;
  logic [8:0]    vrel;
  logic          img, disp_bank, trig;
  logic [CW-1:0] rd_col;
  logic [7:0]    trig_row;
  logic [AW-1:0] row_off;
  logic          fetch_page;

  fetch_state_t  state, state_d;
  logic [CW-1:0] col, col_d, wr_col;
  logic [AW-1:0] base, base_d;
  logic          bank_q, bank_d, wr_bank, wr_vld, urun_d, accept;

  logic [7:0]    lbuf0 [LINE_W];
  logic [7:0]    lbuf1 [LINE_W];

  // Raster counters
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == 10'(H_LAST)) begin
      hc <= '0;
      vc <= (vc == 10'(V_LAST)) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign vrel      = 9'(vc - 10'(IMG_TOP));
  assign img       = (hc < 10'(H_VIS)) && (vc >= 10'(IMG_TOP)) && (vc < 10'(IMG_BOT));
  assign disp_bank = vrel[1];
  assign rd_col    = hc[9:1];

  // Each fetch lands one display line pair ahead; row 199 is only fetched once
  assign trig     = (hc == '0) && ((vc == 10'(IMG_TOP - 1)) ||
                    ((vc >= 10'(IMG_TOP)) && (vc <= 10'(LAST_TRIG)) && vrel[0]));
  assign trig_row = (vc == 10'(IMG_TOP - 1)) ? 8'd0 : vrel[8:1] + 8'd1;
  assign row_off  = (AW'(trig_row) << 8) + (AW'(trig_row) << 6);
  assign accept   = (state == S_REQ) && gnt;

`ifdef VIDSCAN_PAGE_LATCH_EN
  logic page_q;
  always_ff @(posedge clock) begin
    if (!reset_n)                   page_q <= 1'b0;
    else if (hc == '0 && vc == '0)  page_q <= page;
  end
  assign fetch_page = page_q;
`else
  assign fetch_page = page;
`endif

  // Fetch FSM state register and address/request outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      col     <= '0;
      base    <= '0;
      bank_q  <= 1'b0;
      req     <= 1'b0;
      a       <= '0;
      urun    <= 1'b0;
      wr_vld  <= 1'b0;
      wr_col  <= '0;
      wr_bank <= 1'b0;
    end else begin
      state   <= state_d;
      col     <= col_d;
      base    <= base_d;
      bank_q  <= bank_d;
      req     <= (state_d == S_REQ);
      a       <= {1'b0, AW'(base_d + AW'(col_d))};
      urun    <= urun_d;
      wr_vld  <= accept;
      wr_col  <= col;
      wr_bank <= bank_q;
    end
  end

  // Fetch FSM next state; line-end deadline overrides everything
  always_comb begin
    state_d = state;
    col_d   = col;
    base_d  = base;
    bank_d  = bank_q;
    urun_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig) begin
          col_d   = '0;
          base_d  = {fetch_page, 16'h0000} + row_off;
          bank_d  = trig_row[0];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt) begin
          col_d = col + 9'd1;
          if (col == CW'(LINE_W - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (hc == 10'(H_LAST) && state != S_IDLE) begin
      urun_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_vld) begin
      if (wr_bank) lbuf1[wr_col] <= i;
      else         lbuf0[wr_col] <= i;
    end
  end

  // Video outputs, all registered from the same hc/vc
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      px <= '0;
      de <= 1'b0;
      hs <= 1'b1;
      vs <= 1'b1;
    end else begin
      px <= img ? (disp_bank ? lbuf1[rd_col] : lbuf0[rd_col]) : 8'h00;
      de <= (hc < 10'(H_VIS)) && (vc < 10'(V_VIS));
      hs <= !((hc >= 10'(HS_BEG)) && (hc <= 10'(HS_END)));
      vs <= !((vc >= 10'(VS_BEG)) && (vc <= 10'(VS_END)));
    end
  end
endmodule

// File: tb/tb_vidscan.sv
// Directed bench for vidscan: sync timing, row fetch/display, gnt pauses, underrun, page select, reset mid-fetch.
module tb_vidscan;
  logic        clock = 1'b0;
  logic        reset_n, page, req, gnt, de, hs, vs, urun;
  logic [17:0] a;
  logic [7:0]  i, px;

  int          tests = 0, fails = 0, t = 0;
  int          acc_cnt = 0, urun_cnt = 0, hs_low = 0;
  logic [17:0] first_a = '0, last_a = '0;
  logic [7:0]  pend_i = '0;
  logic        gnt_val = 1'b1, mode_tog = 1'b0;

  vidscan dut (
    .clock(clock), .reset_n(reset_n), .page(page), .req(req), .gnt(gnt),
    .a(a), .i(i), .px(px), .de(de), .hs(hs), .vs(vs), .urun(urun)
  );

  initial forever #20 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; memory answers addr[7:0] one cycle after an accepted address
  task automatic tick();
    @(posedge clock);
    t++;
    @(negedge clock);
    i = pend_i;
    gnt = mode_tog ? ~gnt : gnt_val;
    if (req && gnt) begin
      if (acc_cnt == 0) first_a = a;
      last_a = a;
      acc_cnt++;
      pend_i = a[7:0];
    end
    if (urun) urun_cnt++;
  endtask

  // Advance until outputs show raster position (v,h)
  task automatic go(input int v, input int h);
    while (t < v * 800 + h + 1) tick();
  endtask

  task automatic clr();
    acc_cnt = 0;
    first_a = '0;
    last_a  = '0;
  endtask

  initial begin
    reset_n = 1'b0; page = 1'b0; gnt = 1'b1; i = '0;
    repeat (3) tick();
    chk("rst_px", 32'(px), 32'h0);
    chk("rst_de", 32'(de), 32'h0);
    chk("rst_hs", 32'(hs), 32'h1);
    chk("rst_vs", 32'(vs), 32'h1);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_urun", 32'(urun), 32'h0);

    reset_n = 1'b1;
    t = 0;
    for (int h = 0; h < 800; h++) begin
      go(0, h);
      chk("l0_hs", 32'(hs), 32'((h >= 656 && h <= 751) ? 0 : 1));
      chk("l0_de", 32'(de), 32'(h < 640 ? 1 : 0));
      if (!hs) hs_low++;
    end
    chk("hs_low_cnt", 32'(hs_low), 32'd96);
    go(1, 5);
    chk("vs_l1", 32'(vs), 32'h1);

    go(38, 799);
    clr();
    go(39, 10);
    chk("l39_px_border", 32'(px), 32'h0);
    chk("l39_de", 32'(de), 32'h1);
    go(39, 700);
    chk("row0_cnt", 32'(acc_cnt), 32'd320);
    chk("row0_first", 32'(first_a), 32'h00000);
    chk("row0_last", 32'(last_a), 32'h0013F);
    chk("row0_req_done", 32'(req), 32'h0);

    for (int h = 0; h < 641; h++) begin
      go(40, h);
      chk("l40_px", 32'(px), 32'(h < 640 ? (h >> 1) & 8'hFF : 0));
    end

    // Row 1 fetched with gnt toggling every cycle
    go(40, 799);
    clr();
    mode_tog = 1'b1;
    for (int h = 0; h < 640; h++) begin
      go(41, h);
      chk("l41_px", 32'(px), 32'((h >> 1) & 8'hFF));
    end
    go(41, 799);
    chk("row1_cnt", 32'(acc_cnt), 32'd320);
    chk("row1_first", 32'(first_a), 32'h00140);
    chk("row1_last", 32'(last_a), 32'h0027F);
    mode_tog = 1'b0;
    gnt_val  = 1'b1;
    for (int h = 0; h < 640; h++) begin
      go(42, h);
      chk("l42_px", 32'(px), 32'((64 + (h >> 1)) & 8'hFF));
    end

    // Row 5 fetch after a page flip
    go(48, 0);
    page = 1'b1;
    go(48, 799);
    clr();
    go(49, 700);
    chk("row5_cnt", 32'(acc_cnt), 32'd320);
`ifdef VIDSCAN_PAGE_LATCH_EN
    chk("row5_first", 32'(first_a), 32'h00640);
    chk("row5_last", 32'(last_a), 32'h0077F);
`else
    chk("row5_first", 32'(first_a), 32'h10640);
    chk("row5_last", 32'(last_a), 32'h1077F);
`endif
    page = 1'b0;

    // Underrun: grant withdrawn partway through the row 6 fetch
    go(50, 0);
    chk("no_urun_yet", 32'(urun_cnt), 32'd0);
    go(50, 799);
    clr();
    urun_cnt = 0;
    go(51, 100);
    gnt_val = 1'b0;
    go(51, 790);
    chk("ur_req_held", 32'(req), 32'h1);
    chk("ur_urun_early", 32'(urun_cnt), 32'd0);
    go(52, 10);
    chk("ur_pulses", 32'(urun_cnt), 32'd1);
    chk("ur_req_drop", 32'(req), 32'h0);
    chk("ur_accepts", 32'(acc_cnt), 32'd101);
    gnt_val = 1'b1;

    // Reset in the middle of the row 7 fetch
    go(53, 50);
    chk("r7_req", 32'(req), 32'h1);
    chk("r7_addr", 32'(a), 32'h008F2);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_req", 32'(req), 32'h0);
    chk("mid_rst_a", 32'(a), 32'h0);
    chk("mid_rst_de", 32'(de), 32'h0);
    reset_n = 1'b1;
    t = 0;
    go(0, 5);
    chk("post_rst_de", 32'(de), 32'h1);
    chk("post_rst_req", 32'(req), 32'h0);
    chk("post_rst_px", 32'(px), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
